// File: rtl/farm_vehicle_detector.sv
// Farm-road vehicle detector: synchronizes and debounces the loop sensor and holds the
// X request until the signal controller serves the farm road. Optional FVD_STUCK_EN adds stuck-loop detection.
module farm_vehicle_detector #(
    parameter int DEBOUNCE    = 4,
    parameter int WAIT_W      = 16,
    parameter int STUCK_LIMIT = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              loop_raw,
    input  logic [1:0]        fwy,
    output logic              X,
    output logic              det,
    output logic [WAIT_W-1:0] wait_cnt,
    output logic              fault
);

    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_SERVE = 2'd2;
    localparam logic [1:0] S_CLEAR = 2'd3;

    localparam logic [1:0] FWY_GREEN = 2'b00;

    if (DEBOUNCE < 1 || STUCK_LIMIT < 1) begin : g_param_error
        $error("farm_vehicle_detector: DEBOUNCE and STUCK_LIMIT must be at least 1");
    end

    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic            s1;
    logic            s2;
    logic [DB_W-1:0] db_cnt;
    logic [1:0]      state;
    logic [1:0]      state_next;
    logic            x_next;
    logic [WAIT_W-1:0] wait_next;
    logic            fwy_green;
    logic            fwy_red;
    logic            hold;

    // Synchronizer: loop_raw is asynchronous to clk
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= loop_raw;
            s2 <= s1;
        end
    end

    // Debounce: det only flips after s2 has disagreed with it for DEBOUNCE consecutive cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            det    <= 1'b0;
            db_cnt <= '0;
        end else if (s2 == det) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            det    <= s2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

`ifdef FVD_STUCK_EN
    localparam int STK_W = $clog2(STUCK_LIMIT + 1);
    localparam logic [STK_W-1:0] STK_HI = STK_W'(STUCK_LIMIT);

    logic [STK_W-1:0] stuck_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stuck_cnt <= '0;
            fault     <= 1'b0;
        end else if (!det) begin
            stuck_cnt <= '0;
            fault     <= 1'b0;
        end else begin
            if (stuck_cnt != STK_HI) begin
                stuck_cnt <= stuck_cnt + 1'b1;
            end
            if (stuck_cnt >= STK_HI - 1'b1) begin
                fault <= 1'b1;
            end
        end
    end
`else
    assign fault = 1'b0;
`endif

    assign hold      = fault;
    assign fwy_green = (fwy == FWY_GREEN);
    // 2'b11 is an illegal code and counts as RED
    assign fwy_red   = fwy[1];

    always_comb begin
        state_next = state;
        x_next     = 1'b0;
        wait_next  = wait_cnt;
        case (state)
            S_IDLE: begin
                if (det) begin
                    state_next = S_REQ;
                    x_next     = 1'b1;
                    wait_next  = '0;
                end
            end
            S_REQ: begin
                wait_next = sat_inc(wait_cnt);
                x_next    = 1'b1;
                if (fwy_green) begin
                    state_next = S_SERVE;
                    x_next     = det;
                end
            end
            S_SERVE: begin
                // X extends farm green while vehicles remain
                if (fwy_green) begin
                    x_next = det;
                end else begin
                    state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (fwy_red) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (hold) begin
            state_next = S_IDLE;
            x_next     = 1'b0;
            wait_next  = wait_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            X        <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            X        <= x_next;
            wait_cnt <= wait_next;
        end
    end

endmodule

// File: tb/tb_farm_vehicle_detector.sv
// Self-checking bench for farm_vehicle_detector: directed scenarios plus random stimulus
// compared against a behavioural model. Stuck-loop scenario depends on FVD_STUCK_EN.
module tb_farm_vehicle_detector;

    localparam int DEBOUNCE    = 4;
    localparam int WAIT_W      = 16;
    localparam int STUCK_LIMIT = 50;

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              loop_raw = 1'b0;
    logic [1:0]        fwy = RED;
    logic              X;
    logic              det;
    logic [WAIT_W-1:0] wait_cnt;
    logic              fault;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    farm_vehicle_detector #(
        .DEBOUNCE   (DEBOUNCE),
        .WAIT_W     (WAIT_W),
        .STUCK_LIMIT(STUCK_LIMIT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .loop_raw(loop_raw),
        .fwy     (fwy),
        .X       (X),
        .det     (det),
        .wait_cnt(wait_cnt),
        .fault   (fault)
    );

    // Reference model: det flips once the loop level seen two edges ago and the
    // DEBOUNCE-1 levels before it all disagree with det. Request handling tracked
    // as "waiting", "serving", "clearing" flags.
    logic              m_det;
    logic              m_x;
    logic              m_fault;
    logic [WAIT_W-1:0] m_wait;
    logic              m_waiting;
    logic              m_serving;
    logic              m_clearing;
    int                m_run;
    logic              hist[$];

    always @(posedge clk or negedge rst) begin : model
        logic d_old;
        logic f_old;
        logic flip;
        if (!rst) begin
            m_det = 0; m_x = 0; m_fault = 0; m_wait = '0; m_run = 0;
            m_waiting = 0; m_serving = 0; m_clearing = 0;
            hist = {};
            for (int i = 0; i < DEBOUNCE + 2; i++) hist.push_back(1'b0);
        end else begin
            d_old = m_det;
            f_old = m_fault;
            flip = 1'b1;
            for (int i = 0; i < DEBOUNCE; i++)
                if (hist[hist.size() - 2 - i] == d_old) flip = 1'b0;
            if (flip) m_det = !d_old;
            hist.push_back(loop_raw);
            if (hist.size() > DEBOUNCE + 2) void'(hist.pop_front());
`ifdef FVD_STUCK_EN
            if (!d_old) begin
                m_run = 0;
                m_fault = 0;
            end else begin
                m_run++;
                if (m_run >= STUCK_LIMIT) m_fault = 1;
            end
`endif
            if (f_old) begin
                m_waiting = 0; m_serving = 0; m_clearing = 0; m_x = 0;
            end else if (m_waiting) begin
                m_wait = (&m_wait) ? m_wait : m_wait + 1'b1;
                if (fwy == GREEN) begin
                    m_waiting = 0; m_serving = 1; m_x = d_old;
                end else begin
                    m_x = 1;
                end
            end else if (m_serving) begin
                if (fwy == GREEN) m_x = d_old;
                else begin
                    m_serving = 0; m_clearing = 1; m_x = 0;
                end
            end else if (m_clearing) begin
                m_x = 0;
                if (fwy == RED || fwy == 2'b11) m_clearing = 0;
            end else begin
                if (d_old) begin
                    m_waiting = 1; m_wait = '0; m_x = 1;
                end else begin
                    m_x = 0;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        loop_raw = 1'b0;
        fwy = RED;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        loop_raw = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({X, det, wait_cnt, fault} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got X=%0b det=%0b wait=%0d fault=%0b, need all 0", X, det, wait_cnt, fault);
        end
        rst = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(negedge clk);
            n_checks++;
            if (det !== (e >= 6) || X !== (e >= 7)) begin
                n_fail++;
                $display("FAIL reset_release_latency edge %0d: got det=%0b X=%0b, need det=%0b X=%0b",
                         e, det, X, e >= 6, e >= 7);
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        loop_raw = 1'b1;
        repeat (3) @(negedge clk);
        loop_raw = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_checks++;
            if (det !== 1'b0 || X !== 1'b0 || {X, det, wait_cnt, fault} !== {m_x, m_det, m_wait, m_fault}) begin
                n_fail++;
                $display("FAIL glitch cycle %0d: got det=%0b X=%0b, need det=0 X=0", c, det, X);
            end
        end
    endtask

    task automatic test_full_cycle();
        int waited;
        do_reset();
        loop_raw = 1'b1;
        waited = 0;
        while (X !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (X !== 1'b1) begin
            n_fail++;
            $display("FAIL full_request_timeout: got X=%0b after %0d cycles, need 1", X, waited);
        end
        repeat (20) @(negedge clk);
        n_checks++;
        if (X !== 1'b1 || wait_cnt !== 16'd20) begin
            n_fail++;
            $display("FAIL full_wait_20: got X=%0b wait=%0d, need X=1 wait=20", X, wait_cnt);
        end
        fwy = GREEN;
        repeat (2) @(negedge clk);
        n_checks++;
        if (X !== 1'b1) begin
            n_fail++;
            $display("FAIL full_green_x: got X=%0b, need 1", X);
        end
        loop_raw = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (det !== 1'b0 || X !== 1'b0) begin
            n_fail++;
            $display("FAIL full_green_empty: got det=%0b X=%0b, need 0 0", det, X);
        end
        loop_raw = 1'b1;
        repeat (8) @(negedge clk);
        n_checks++;
        if (det !== 1'b1 || X !== 1'b1) begin
            n_fail++;
            $display("FAIL full_green_extend: got det=%0b X=%0b, need 1 1", det, X);
        end
        fwy = YELLOW;
        @(negedge clk);
        n_checks++;
        if (X !== 1'b0 || wait_cnt !== 16'd21) begin
            n_fail++;
            $display("FAIL full_yellow: got X=%0b wait=%0d, need X=0 wait=21", X, wait_cnt);
        end
        fwy = RED;
        @(negedge clk);
        n_checks++;
        if (X !== 1'b0) begin
            n_fail++;
            $display("FAIL full_red_edge1: got X=%0b, need 0", X);
        end
        @(negedge clk);
        n_checks++;
        if (X !== 1'b1 || wait_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL full_red_reassert: got X=%0b wait=%0d, need X=1 wait=0", X, wait_cnt);
        end
    endtask

    task automatic test_latched();
        do_reset();
        loop_raw = 1'b1;
        repeat (9) @(negedge clk);
        loop_raw = 1'b0;
        repeat (12) @(negedge clk);
        n_checks++;
        if (det !== 1'b0 || X !== 1'b1) begin
            n_fail++;
            $display("FAIL latched_hold: got det=%0b X=%0b, need det=0 X=1", det, X);
        end
        fwy = GREEN;
        @(negedge clk);
        n_checks++;
        if (X !== 1'b0) begin
            n_fail++;
            $display("FAIL latched_serve_empty: got X=%0b, need 0", X);
        end
        @(negedge clk);
        n_checks++;
        if (X !== 1'b0) begin
            n_fail++;
            $display("FAIL latched_serve_stay: got X=%0b, need 0", X);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        loop_raw = 1'b1;
        repeat (12) @(negedge clk);
        fwy = GREEN;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (X !== 1'b0 || det !== 1'b0 || wait_cnt !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got X=%0b det=%0b wait=%0d, need all 0", X, det, wait_cnt);
        end
        @(negedge clk);
        fwy = RED;
        rst = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(negedge clk);
            n_checks++;
            if (det !== (e >= 6) || X !== (e >= 7)) begin
                n_fail++;
                $display("FAIL async_release edge %0d: got det=%0b X=%0b, need det=%0b X=%0b",
                         e, det, X, e >= 6, e >= 7);
            end
        end
    endtask

    task automatic test_stuck();
        do_reset();
        loop_raw = 1'b1;
`ifdef FVD_STUCK_EN
        repeat (6) @(negedge clk);
        for (int c = 1; c <= STUCK_LIMIT; c++) begin
            @(negedge clk);
            n_checks++;
            if (fault !== (c >= STUCK_LIMIT)) begin
                n_fail++;
                $display("FAIL stuck_fault cycle %0d: got %0b, need %0b", c, fault, c >= STUCK_LIMIT);
            end
        end
        @(negedge clk);
        n_checks++;
        if (X !== 1'b0) begin
            n_fail++;
            $display("FAIL stuck_x_forced: got X=%0b, need 0", X);
        end
        loop_raw = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (det !== 1'b0 || fault !== 1'b1) begin
            n_fail++;
            $display("FAIL stuck_det_fall: got det=%0b fault=%0b, need 0 1", det, fault);
        end
        @(negedge clk);
        n_checks++;
        if (fault !== 1'b0) begin
            n_fail++;
            $display("FAIL stuck_clear: got fault=%0b, need 0", fault);
        end
`else
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            n_checks++;
            if (fault !== 1'b0) begin
                n_fail++;
                $display("FAIL stuck_tied_off cycle %0d: got fault=%0b, need 0", c, fault);
            end
        end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(5) == 0) loop_raw = ~loop_raw;
            if ($urandom_range(9) == 0) fwy = 2'($urandom_range(3));
            @(negedge clk);
            n_checks++;
            if ({X, det, wait_cnt, fault} !== {m_x, m_det, m_wait, m_fault}) begin
                n_fail++;
                $display("FAIL random cycle %0d: got X=%0b det=%0b wait=%0d fault=%0b, need X=%0b det=%0b wait=%0d fault=%0b",
                         c, X, det, wait_cnt, fault, m_x, m_det, m_wait, m_fault);
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_full_cycle();
        test_latched();
        test_async_reset();
        test_stuck();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
